// File: rtl/master_fsm_if.sv
// master_fsm_if: producer-side byte stream plus the 4-phase req/ack link wires
// and status of the master_fsm initiator.
//   send_valid/send_data/send_ready : producer push handshake into the FIFO
//   req/data_out/ack                : 4-phase link towards the responder
//   busy/timeout_err/sent_count     : initiator status
// modport master : view of the initiator (master_fsm)
// modport slave  : view of the producer/responder side
interface master_fsm_if;
  logic       send_valid;
  logic [7:0] send_data;
  logic       send_ready;
  logic       req;
  logic [7:0] data_out;
  logic       ack;
  logic       busy;
  logic       timeout_err;
  logic [7:0] sent_count;

  modport master (
    input  send_valid, send_data, ack,
    output send_ready, req, data_out, busy, timeout_err, sent_count
  );

  modport slave (
    output send_valid, send_data, ack,
    input  send_ready, req, data_out, busy, timeout_err, sent_count
  );
endinterface

// File: rtl/master_fsm.sv
// master_fsm: initiator of a 4-phase req/ack byte link.
// Bytes pushed by the local producer are queued in a DEPTH-entry FIFO and sent
// one per handshake: raise req with data, wait ack, drop req, wait ack low.
// A handshake whose ack does not arrive within TIMEOUT cycles of req high is
// abandoned (one-cycle timeout_err pulse) and the same byte is retried.
// Ports:
//   clk   : clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   link  : master_fsm_if.master (producer push, link wires, status)
module master_fsm #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  master_fsm_if.master   link
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [TW-1:0] T_ONE   = 1;
  localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ_HI = 2'd1;
  localparam logic [1:0] ACK_LO = 2'd2;

  logic [1:0]    state;
  logic [TW-1:0] tcnt;

  // FIFO: pointers carry one extra wrap bit so full and empty are distinct.
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [7:0]  head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign push = link.send_valid && !full;
  // A byte leaves the FIFO only once the responder has accepted it; a timeout
  // leaves it at the head so the next handshake retries it.
  assign pop  = (state == REQ_HI) && link.ack;

  assign link.send_ready = !full;
  assign link.busy       = (state != IDLE) || !empty;

  // NOTE: storage has no reset; only the pointers define FIFO contents, so
  // clearing them empties the queue and the array can stay plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= link.send_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      tcnt             <= '0;
      link.req         <= 1'b0;
      link.data_out    <= 8'h00;
      link.timeout_err <= 1'b0;
      link.sent_count  <= 8'h00;
    end else begin
      link.timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          // A stale ack from the previous handshake blocks the next request.
          if (!empty && !link.ack) begin
            state         <= REQ_HI;
            link.req      <= 1'b1;
            link.data_out <= head;
            tcnt          <= T_ONE;
          end
        end
        REQ_HI: begin
          // ack has priority over an expiring timeout on the same edge.
          if (link.ack) begin
            state           <= ACK_LO;
            link.req        <= 1'b0;
            link.sent_count <= link.sent_count + 8'd1;
          end else if (tcnt == T_MAX) begin
            state            <= ACK_LO;
            link.req         <= 1'b0;
            link.timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + T_ONE;
          end
        end
        ACK_LO: begin
          if (!link.ack) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          link.req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_master_fsm.sv
// tb_master_fsm: directed tests for master_fsm with a behavioural responder
// (modes: ack tied 0, ack held 1, or ack after a programmable delay held until
// req falls) and a monitor capturing data_out on every req rising edge.
module tb_master_fsm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  master_fsm_if link ();

  master_fsm #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Responder and monitor act on the falling edge, away from DUT sampling.
  int         ack_mode = 0;  // 0: ack=0, 1: ack=1, 2: delayed auto-ack
  int         ack_dly  = 0;
  int         rcnt     = 0;
  logic       req_q    = 1'b0;
  logic       terr_seen = 1'b0;
  logic [7:0] cap [$];

  always @(negedge clk) begin
    case (ack_mode)
      0: begin link.ack = 1'b0; rcnt = 0; end
      1: begin link.ack = 1'b1; rcnt = 0; end
      default: begin
        if (!link.req) begin
          link.ack = 1'b0;
          rcnt = 0;
        end else if (!link.ack) begin
          if (rcnt >= ack_dly) begin
            link.ack = 1'b1;
            rcnt = 0;
          end else begin
            rcnt++;
          end
        end
      end
    endcase
    if (link.req && !req_q) cap.push_back(link.data_out);
    req_q = link.req;
    if (link.timeout_err) terr_seen = 1'b1;
  end

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (link.busy && n < limit) begin
      tick();
      n++;
    end
    check(tag, link.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pushes, cnt;
    logic did;

    rst_n = 1'b0;
    link.send_valid = 1'b0;
    link.send_data  = 8'h00;
    link.ack        = 1'b0;
    #12;
    check("rst_req",   link.req, 1'b0);
    check("rst_data",  link.data_out, 8'h00);
    check("rst_terr",  link.timeout_err, 1'b0);
    check("rst_count", link.sent_count, 8'h00);
    check("rst_busy",  link.busy, 1'b0);
    check("rst_ready", link.send_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Test 1: single byte, fast responder.
    ack_mode = 2; ack_dly = 0;
    link.send_valid = 1'b1; link.send_data = 8'hA5;
    check("t1_ready", link.send_ready, 1'b1);
    tick();
    link.send_valid = 1'b0;
    check("t1_req_not_yet", link.req, 1'b0);
    tick();
    check("t1_req_rise", link.req, 1'b1);
    check("t1_data", link.data_out, 8'hA5);
    tick();
    check("t1_req_fall", link.req, 1'b0);
    check("t1_count", link.sent_count, 8'd1);
    check("t1_busy_lo_wait", link.busy, 1'b1);
    tick();
    check("t1_busy_idle", link.busy, 1'b0);

    // Test 2: five back-to-back pushes against a slow responder.
    ack_dly = 10;
    cap.delete();
    link.send_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      link.send_data = 8'(i);
      tick();
    end
    link.send_data = 8'h05;
    check("t2_full_ready", link.send_ready, 1'b0);
    n = 0;
    while (!link.send_ready && n < 100) begin
      tick();
      n++;
    end
    check("t2_ready_return", link.send_ready, 1'b1);
    tick();
    link.send_valid = 1'b0;
    wait_idle("t2_idle", 300);
    check("t2_cap_size", cap.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t2_order%0d", i), (i < cap.size()) ? cap[i] : 8'hxx, 8'(i + 1));
    check("t2_count", link.sent_count, 8'd6);

    // Test 3: ack tied low -> timeout and retry.
    ack_mode = 0;
    link.send_valid = 1'b1; link.send_data = 8'h3C;
    tick();
    link.send_valid = 1'b0;
    n = 0;
    while (!link.req && n < 10) begin
      tick();
      n++;
    end
    check("t3_req_rise", link.req, 1'b1);
    cnt = 0;
    while (link.req && cnt < 40) begin
      cnt++;
      tick();
    end
    check("t3_req_high_cycles", cnt, 16);
    check("t3_terr_pulse", link.timeout_err, 1'b1);
    tick();
    check("t3_terr_clear", link.timeout_err, 1'b0);
    check("t3_req_low_gap", link.req, 1'b0);
    tick();
    check("t3_retry_req", link.req, 1'b1);
    check("t3_retry_data", link.data_out, 8'h3C);
    check("t3_count_held", link.sent_count, 8'd6);
    ack_mode = 2; ack_dly = 0;
    wait_idle("t3_idle", 50);
    check("t3_count_after", link.sent_count, 8'd7);

    // Test 4: stale ack held high while idle.
    ack_mode = 1;
    tick();
    link.send_valid = 1'b1; link.send_data = 8'h77;
    tick();
    link.send_valid = 1'b0;
    tick(); tick(); tick();
    check("t4_req_blocked", link.req, 1'b0);
    check("t4_busy", link.busy, 1'b1);
    ack_mode = 2;
    tick();
    check("t4_req_after_drop", link.req, 1'b1);
    check("t4_data", link.data_out, 8'h77);
    wait_idle("t4_idle", 50);
    check("t4_count", link.sent_count, 8'd8);

    // Test 5: reset in the middle of a handshake with two bytes queued.
    ack_mode = 0;
    link.send_valid = 1'b1;
    link.send_data = 8'hAA; tick();
    link.send_data = 8'hBB; tick();
    link.send_data = 8'hCC; tick();
    link.send_valid = 1'b0;
    check("t5_req_inflight", link.req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_req",   link.req, 1'b0);
    check("t5_rst_data",  link.data_out, 8'h00);
    check("t5_rst_busy",  link.busy, 1'b0);
    check("t5_rst_count", link.sent_count, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("t5_no_req", link.req, 1'b0);
    check("t5_still_idle", link.busy, 1'b0);

    // Test 6: 256 transfers wrap sent_count.
    ack_mode = 2; ack_dly = 0;
    cap.delete();
    terr_seen = 1'b0;
    pushes = 0; n = 0;
    link.send_valid = 1'b1; link.send_data = 8'h00;
    while (pushes < 256 && n < 5000) begin
      did = link.send_ready;
      tick();
      n++;
      if (did) begin
        pushes++;
        link.send_data = 8'(pushes);
      end
    end
    link.send_valid = 1'b0;
    check("t6_pushes", pushes, 256);
    wait_idle("t6_idle", 100);
    check("t6_count_wrap", link.sent_count, 8'h00);
    check("t6_no_timeout", terr_seen, 1'b0);
    check("t6_cap_size", cap.size(), 256);
    check("t6_last_byte", (cap.size() == 256) ? cap[255] : 8'hxx, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
